// File: rtl/alu.sv
// Single-cycle 32-bit ALU for the execute stage.
// Result, zero flag and signed-overflow flag are registered on the rising edge.
module alu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data1_i,
   input  logic [31:0] data2_i,
   input  logic [2:0]  ALUCtrl_i,
   output logic [31:0] data_o,
   output logic        Zero_o,
   output logic        Overflow_o
);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_MUL = 3'b011,
      OP_XOR = 3'b100,
      OP_NOR = 3'b101,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } op_e;

   op_e         op;
   logic [31:0] sum, diff;
   logic        add_ovf, sub_ovf;
   logic [31:0] data_d, data_q;
   logic        zero_d, zero_q;
   logic        ovf_d, ovf_q;

   assign op      = op_e'(ALUCtrl_i);
   assign sum     = data1_i + data2_i;
   assign diff    = data1_i - data2_i;
   assign add_ovf = (data1_i[31] == data2_i[31]) && (sum[31] != data1_i[31]);
   assign sub_ovf = (data1_i[31] != data2_i[31]) && (diff[31] != data1_i[31]);

   always_comb begin
      data_d = '0;
      ovf_d  = 1'b0;
      case (op)
         OP_AND: data_d = data1_i & data2_i;
         OP_OR:  data_d = data1_i | data2_i;
         OP_ADD: begin
            data_d = sum;
            ovf_d  = add_ovf;
         end
         OP_MUL: data_d = data1_i * data2_i;
         OP_XOR: data_d = data1_i ^ data2_i;
         OP_NOR: data_d = ~(data1_i | data2_i);
         OP_SUB: begin
            data_d = diff;
            ovf_d  = sub_ovf;
         end
         // Signed less-than: sign of the difference corrected by overflow; flag stays clear.
         OP_SLT: data_d = {31'b0, diff[31] ^ sub_ovf};
         default: data_d = '0;
      endcase
      zero_d = (data_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign data_o     = data_q;
   assign Zero_o     = zero_q;
   assign Overflow_o = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps plus randomized
// operations checked against an arithmetic reference model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [2:0]  ctrl;
   logic [31:0] data_o;
   logic        Zero_o, Overflow_o;

   int passed = 0;
   int total  = 0;

   alu dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .data1_i    (a),
      .data2_i    (b),
      .ALUCtrl_i  (ctrl),
      .data_o     (data_o),
      .Zero_o     (Zero_o),
      .Overflow_o (Overflow_o)
   );

   always #5 clk = ~clk;

   // Reference model: plain signed/unsigned arithmetic on wide integers.
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [2:0] mc, output logic [31:0] md,
                                 output logic mz, output logic mo);
      longint sa, sb, r;
      logic [63:0] p;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      mo = 1'b0;
      md = '0;
      case (mc)
         3'd0: md = ma & mb;
         3'd1: md = ma | mb;
         3'd2: begin
            r  = sa + sb;
            md = r[31:0];
            mo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         3'd3: begin
            p  = {32'b0, ma} * {32'b0, mb};
            md = p[31:0];
         end
         3'd4: md = ma ^ mb;
         3'd5: md = ~(ma | mb);
         3'd6: begin
            r  = sa - sb;
            md = r[31:0];
            mo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         default: md = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      mz = (md == 32'd0);
   endfunction

   task automatic check(input string tag, input logic [31:0] ed, input logic ez, input logic eo);
      total++;
      assert (data_o === ed) passed++;
      else $error("FAIL %s data_o: got %h expected %h", tag, data_o, ed);
      total++;
      assert (Zero_o === ez) passed++;
      else $error("FAIL %s Zero_o: got %b expected %b", tag, Zero_o, ez);
      total++;
      assert (Overflow_o === eo) passed++;
      else $error("FAIL %s Overflow_o: got %b expected %b", tag, Overflow_o, eo);
   endtask

   // Present inputs, clock one edge, check against the model (or reset values).
   task automatic step(input string tag, input logic r, input logic [31:0] ta,
                       input logic [31:0] tb, input logic [2:0] tc);
      logic [31:0] ed;
      logic ez, eo;
      rst = r; a = ta; b = tb; ctrl = tc;
      model(ta, tb, tc, ed, ez, eo);
      if (r) begin
         ed = '0; ez = 1'b1; eo = 1'b0;
      end
      @(posedge clk);
      #1;
      check(tag, ed, ez, eo);
   endtask

   // Same as step, but against hand-derived constants from the test plan.
   task automatic dstep(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [2:0] tc, input logic [31:0] ed, input logic ez,
                        input logic eo);
      rst = 1'b0; a = ta; b = tb; ctrl = tc;
      @(posedge clk);
      #1;
      check(tag, ed, ez, eo);
   endtask

   initial begin
      logic [31:0] ra, rb, hold_d;
      logic        hold_z, hold_o;

      rst = 1'b1; a = $urandom; b = $urandom; ctrl = 3'($urandom);
      @(posedge clk); #1;
      check("reset1", 32'd0, 1'b1, 1'b0);
      a = $urandom; b = $urandom; ctrl = 3'($urandom);
      @(posedge clk); #1;
      check("reset2", 32'd0, 1'b1, 1'b0);

      dstep("or_first", 32'd100, 32'd28, 3'b001, 32'd124, 1'b0, 1'b0);
      dstep("or",  32'd56, 32'd31, 3'b001, 32'd63, 1'b0, 1'b0);
      dstep("and", 32'd56, 32'd31, 3'b000, 32'd24, 1'b0, 1'b0);
      dstep("xor", 32'd56, 32'd31, 3'b100, 32'd39, 1'b0, 1'b0);
      dstep("nor", 32'd56, 32'd31, 3'b101, 32'hFFFFFFC0, 1'b0, 1'b0);
      dstep("add", 32'd100, 32'd28, 3'b010, 32'd128, 1'b0, 1'b0);
      dstep("sub", 32'd56, 32'd31, 3'b110, 32'd25, 1'b0, 1'b0);
      dstep("sub_zero", 32'd5, 32'd5, 3'b110, 32'd0, 1'b1, 1'b0);
      dstep("mul", 32'd100, 32'd28, 3'b011, 32'd2800, 1'b0, 1'b0);
      dstep("mul_wrap", 32'hFFFFFFFF, 32'd2, 3'b011, 32'hFFFFFFFE, 1'b0, 1'b0);
      dstep("add_ovf", 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b1);
      dstep("sub_ovf", 32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1);
      dstep("add_wrap", 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b1, 1'b0);
      dstep("slt_neg", 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
      dstep("slt_pos", 32'd1, 32'hFFFFFFFF, 3'b111, 32'd0, 1'b1, 1'b0);
      dstep("slt_ovf", 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1, 1'b0, 1'b0);
      dstep("slt_min1", 32'h80000000, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);

      // Inputs changing between edges must not disturb registered outputs.
      hold_d = data_o; hold_z = Zero_o; hold_o = Overflow_o;
      a = 32'h12345678; b = 32'h0; ctrl = 3'b001;
      #3;
      check("between_edges", hold_d, hold_z, hold_o);

      // Back-to-back sweep of all codes with a mid-stream reset.
      for (int unsigned c = 0; c < 8; c++)
         step("sweep", 1'b0, $urandom, $urandom, 3'(c));
      step("mid_rst", 1'b1, 32'h7FFFFFFF, 32'd1, 3'b010);
      for (int unsigned c = 0; c < 8; c++)
         step("resume", 1'b0, $urandom, $urandom, 3'(c));

      // Randomized operations, biased toward sign-boundary operands.
      for (int i = 0; i < 400; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
            1: ra = 32'h80000000 + 32'($urandom_range(0, 3));
            2: rb = ra;
            3: rb = 32'($urandom_range(0, 3));
            default: ;
         endcase
         step("random", ($urandom_range(0, 19) == 0), ra, rb, 3'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
